ch_cfg_write_sched: RTL and testbench



---
 rtl/ch_cfg_write_sched_pkg.sv | 19 +
 rtl/ch_cfg_rr_arb.sv | 32 +++
 rtl/ch_cfg_write_sched.sv | 131 +++++++++++++
 tb/tb_ch_cfg_write_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ch_cfg_write_sched_pkg.sv
// Shared definitions for the channel-config write scheduler: FSM encoding,
// default request length limit and well-known channel register addresses.
package ch_cfg_write_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int CFG_MAX_LEN = 6;

    localparam logic [7:0] FREQ_INC_B0  = 8'h03;
    localparam logic [7:0] FREQ_INC_B5  = 8'h08;
    localparam logic [7:0] CH_ON_OFF    = 8'h2D;
    localparam logic [7:0] PRBS_MODE    = 8'h40;
    localparam logic [7:0] PRBS_RATE_B0 = 8'h42;

endpackage

// File: rtl/ch_cfg_rr_arb.sv
// Two-way round-robin grant; on contention the requester not served last wins.
module ch_cfg_rr_arb (
    input  logic       CLK_LOW,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] ready,
    output logic       grant
);
    logic last_grant;

    always_comb begin
        grant = 1'b0;
        case (valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
        ready = 2'b00;
        if (en)
            ready[grant] = valid[grant];
    end

    // Reset value of 1 lets requester 0 win the first contention.
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n)
            last_grant <= 1'b1;
        else if (|ready)
            last_grant <= grant;
    end

endmodule

// File: rtl/ch_cfg_write_sched.sv
// Serialises multi-byte register writes from two requesters onto the channel
// config byte bus, with GAP_CYCLES idle cycles after every byte.
module ch_cfg_write_sched
    import ch_cfg_write_sched_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_LEN    = CFG_MAX_LEN
) (
    input  logic        CLK_LOW,
    input  logic        reset_n,
    input  logic        REQ0_VALID,
    input  logic [7:0]  REQ0_ADDR,
    input  logic [2:0]  REQ0_LEN,
    input  logic [47:0] REQ0_DATA,
    output logic        REQ0_READY,
    input  logic        REQ1_VALID,
    input  logic [7:0]  REQ1_ADDR,
    input  logic [2:0]  REQ1_LEN,
    input  logic [47:0] REQ1_DATA,
    output logic        REQ1_READY,
    output logic        CH_CONFIG_WE,
    output logic [7:0]  CH_CONFIG_ADDR,
    output logic [7:0]  CH_CONFIG_DATA,
    output logic        BUSY,
    output logic        ERR_LEN
);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [2:0]  idx, idx_n, len_q;
    logic [3:0]  gap_cnt, gap_n;
    logic [7:0]  base_q, addr_n, data_n;
    logic [47:0] pay_q;
    logic        load, we_n, err_n, xfer, grant, len_ok;
    logic [1:0]  ready;
    logic [7:0]  sel_addr;
    logic [2:0]  sel_len;
    logic [47:0] sel_data;

    ch_cfg_rr_arb u_arb (
        .CLK_LOW (CLK_LOW),
        .reset_n (reset_n),
        .en      (state == IDLE),
        .valid   ({REQ1_VALID, REQ0_VALID}),
        .ready   (ready),
        .grant   (grant)
    );

    assign REQ0_READY = ready[0];
    assign REQ1_READY = ready[1];
    assign xfer       = |ready;
    assign sel_addr   = grant ? REQ1_ADDR : REQ0_ADDR;
    assign sel_len    = grant ? REQ1_LEN  : REQ0_LEN;
    assign sel_data   = grant ? REQ1_DATA : REQ0_DATA;
    assign len_ok     = (sel_len != 3'd0) && ({29'd0, sel_len} <= MAX_LEN);

    // Outputs are computed for the next state so WE lands in the cycle after the transfer.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        gap_n   = gap_cnt;
        load    = 1'b0;
        we_n    = 1'b0;
        err_n   = 1'b0;
        addr_n  = CH_CONFIG_ADDR;
        data_n  = CH_CONFIG_DATA;
        case (state)
            IDLE: if (xfer) begin
                load  = 1'b1;
                idx_n = '0;
                if (len_ok) begin
                    state_n = WRITE;
                    we_n    = 1'b1;
                    addr_n  = sel_addr;
                    data_n  = sel_data[7:0];
                end else begin
                    err_n = 1'b1;
                end
            end
            WRITE: begin
                state_n = GAP;
                gap_n   = '0;
            end
            GAP: if (gap_cnt == GAP_LAST) begin
                if (idx == len_q - 3'd1) begin
                    state_n = IDLE;
                end else begin
                    idx_n   = idx + 3'd1;
                    state_n = WRITE;
                    we_n    = 1'b1;
                    addr_n  = base_q + {5'd0, idx_n};
                    data_n  = pay_q[{idx_n, 3'b000} +: 8];
                end
            end else begin
                gap_n = gap_cnt + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            gap_cnt        <= '0;
            base_q         <= '0;
            len_q          <= '0;
            pay_q          <= '0;
            CH_CONFIG_WE   <= 1'b0;
            CH_CONFIG_ADDR <= '0;
            CH_CONFIG_DATA <= '0;
            BUSY           <= 1'b0;
            ERR_LEN        <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            gap_cnt        <= gap_n;
            if (load) begin
                base_q <= sel_addr;
                len_q  <= sel_len;
                pay_q  <= sel_data;
            end
            CH_CONFIG_WE   <= we_n;
            CH_CONFIG_ADDR <= addr_n;
            CH_CONFIG_DATA <= data_n;
            BUSY           <= (state_n != IDLE);
            ERR_LEN        <= err_n;
        end
    end

endmodule

// File: tb/tb_ch_cfg_write_sched.sv
// Cycle-level scoreboard bench: a transaction model predicts grants, the
// per-cycle write schedule, BUSY and ERR_LEN from request arithmetic.
module tb_ch_cfg_write_sched;
    import ch_cfg_write_sched_pkg::*;

    localparam int GAP = 1;

    typedef struct packed {
        logic [7:0]  addr;
        logic [2:0]  len;
        logic [47:0] data;
    } req_t;

    logic        CLK_LOW = 1'b0, reset_n;
    logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
    logic [7:0]  REQ0_ADDR, REQ1_ADDR;
    logic [2:0]  REQ0_LEN, REQ1_LEN;
    logic [47:0] REQ0_DATA, REQ1_DATA;
    logic        CH_CONFIG_WE, BUSY, ERR_LEN;
    logic [7:0]  CH_CONFIG_ADDR, CH_CONFIG_DATA;

    ch_cfg_write_sched #(.GAP_CYCLES(GAP), .MAX_LEN(6)) dut (
        .CLK_LOW(CLK_LOW), .reset_n(reset_n),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_LEN(REQ0_LEN),
        .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_LEN(REQ1_LEN),
        .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .CH_CONFIG_WE(CH_CONFIG_WE), .CH_CONFIG_ADDR(CH_CONFIG_ADDR),
        .CH_CONFIG_DATA(CH_CONFIG_DATA), .BUSY(BUSY), .ERR_LEN(ERR_LEN)
    );

    always #5 CLK_LOW = ~CLK_LOW;

    int checks = 0, errors = 0;
    int cyc = 0, free_at = 0, busy_lo = 0, err_at = -1;
    int hold0 = 0, hold1 = 0;
    bit in_rst = 1'b1, rnd = 1'b0, last_g = 1'b1, v0, v1, g, xfer;
    logic [7:0] exp_addr = 8'h00, exp_data = 8'h00;
    logic [15:0] we_map [int];
    req_t q0 [$];
    req_t q1 [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        we_map.delete();
        free_at  = 0;
        busy_lo  = 0;
        err_at   = -1;
        last_g   = 1'b1;
        exp_addr = 8'h00;
        exp_data = 8'h00;
    endtask

    task automatic drive();
        if (hold0 > 0) hold0--;
        if (hold1 > 0) hold1--;
        v0 = !in_rst && q0.size() > 0 && hold0 == 0;
        v1 = !in_rst && q1.size() > 0 && hold1 == 0;
        REQ0_VALID = v0;
        REQ1_VALID = v1;
        {REQ0_ADDR, REQ0_LEN, REQ0_DATA} = (q0.size() > 0) ? q0[0] : '0;
        {REQ1_ADDR, REQ1_LEN, REQ1_DATA} = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic check_cycle();
        bit idle, ewe;
        idle = !in_rst && cyc >= free_at;
        g    = (v0 && v1) ? !last_g : v1;
        xfer = idle && (v0 || v1);
        ewe  = we_map.exists(cyc);
        if (ewe) begin
            {exp_addr, exp_data} = we_map[cyc];
            we_map.delete(cyc);
        end
        chk("ready0", 64'(REQ0_READY), 64'(idle && v0 && !g));
        chk("ready1", 64'(REQ1_READY), 64'(idle && v1 && g));
        chk("we",     64'(CH_CONFIG_WE), 64'(ewe));
        chk("addr",   64'(CH_CONFIG_ADDR), 64'(exp_addr));
        chk("data",   64'(CH_CONFIG_DATA), 64'(exp_data));
        chk("busy",   64'(BUSY), 64'(cyc >= busy_lo && cyc < free_at));
        chk("err",    64'(ERR_LEN), 64'(cyc == err_at));
    endtask

    task automatic apply_xfer();
        req_t r;
        logic [7:0] a;
        if (!xfer) return;
        if (g) begin r = q1.pop_front(); hold1 = rnd ? $urandom_range(0, 3) : 0; end
        else   begin r = q0.pop_front(); hold0 = rnd ? $urandom_range(0, 3) : 0; end
        last_g = g;
        if (r.len != 3'd0 && r.len <= 3'd6) begin
            for (int k = 0; k < int'(r.len); k++) begin
                a = r.addr + k[7:0];
                we_map[cyc + 1 + k * (GAP + 1)] = {a, r.data[8 * k +: 8]};
            end
            busy_lo = cyc + 1;
            free_at = cyc + 1 + int'(r.len) * (GAP + 1);
        end else begin
            err_at  = cyc + 1;
            free_at = cyc + 1;
        end
    endtask

    task automatic tick();
        @(negedge CLK_LOW);
        check_cycle();
        @(posedge CLK_LOW);
        apply_xfer();
        cyc++;
        #1 drive();
    endtask

    task automatic push(input int who, input logic [7:0] a, input logic [2:0] l, input logic [47:0] d);
        req_t r;
        r = '{addr: a, len: l, data: d};
        if (who == 0) q0.push_back(r);
        else          q1.push_back(r);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n >= 3000), 64'(0));
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        in_rst = 1'b1;
        model_reset();
        drive();
        repeat (2) tick();
        reset_n = 1'b1;
        in_rst  = 1'b0;
        free_at = cyc;
        drive();
    endtask

    function automatic logic [2:0] rnd_len();
        if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
        return 3'($urandom_range(1, 6));
    endfunction

    initial begin
        int n;
        reset_n = 1'b0;
        model_reset();
        drive();
        repeat (2) tick();
        reset_n = 1'b1;
        in_rst  = 1'b0;
        free_at = cyc;
        drive();

        push(0, FREQ_INC_B0, 3'd6, 48'h1234_5678_9ABC);
        wait_idle();

        push(0, PRBS_MODE, 3'd1, 48'h01);
        push(1, CH_ON_OFF, 3'd1, 48'h01);
        wait_idle();
        push(0, 8'h10, 3'd1, 48'h5A);
        wait_idle();
        push(0, PRBS_MODE, 3'd1, 48'h02);
        push(1, CH_ON_OFF, 3'd1, 48'h00);
        wait_idle();

        push(1, 8'hFF, 3'd2, 48'hAA55);
        wait_idle();

        push(0, 8'h20, 3'd0, 48'h11);
        push(0, 8'h21, 3'd7, 48'h22);
        wait_idle();

        // Abandon a 6-byte request mid-way, then prove a fresh one still runs.
        push(0, FREQ_INC_B0, 3'd6, 48'hCAFE_F00D_BEEF);
        tick();
        tick();
        n = 0;
        while (cyc < busy_lo + 5 && n < 50) begin tick(); n++; end
        chk("reset_point", 64'(cyc), 64'(busy_lo + 5));
        pulse_reset();
        repeat (4) tick();
        push(1, PRBS_RATE_B0, 3'd4, {$urandom, $urandom});
        wait_idle();

        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3)
                push(0, 8'($urandom), rnd_len(), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0 && q1.size() < 3)
                push(1, 8'($urandom), rnd_len(), {$urandom, $urandom});
            tick();
        end
        wait_idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
